bayer_window_stream: RTL and testbench

- Parametrised successor to the fixed counter, window-buffer and RGGB datapath.
- Accepts a raster Bayer pixel stream, one pixel per beat, under valid/ready.
- Keeps one line buffer and emits a 2x2 window per pixel at row>=1, col>=1, reordered to {R,Gr,Gb,B}.
- Sits between the SDRAM read path and filterTopLevel; supports runtime frame size and backpressure.

---
 rtl/bayer_window_stream.sv | 200 ++++++++++++++++++++
 tb/tb_bayer_window_stream.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_window_stream.sv
// Bayer 2x2 window streamer: one line buffer, raster pixel input, {R,Gr,Gb,B} window output under valid/ready.
// Optional backpressure counter on stall_cycles is built when BWS_STALL_CNT_EN is defined.
module bayer_window_stream #(
    parameter int PIX_W = 8,
    parameter int MAX_W = 4096,
    parameter int DIM_W = 13
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [DIM_W-1:0]   img_width,
    input  logic [DIM_W-1:0]   img_height,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
    output logic               win_valid,
    output logic [4*PIX_W-1:0] win_data,
    output logic [DIM_W-1:0]   win_row,
    output logic [DIM_W-1:0]   win_col,
    input  logic               win_ready,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [31:0]        stall_cycles
);
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   width_q, width_d, height_q, height_d;
    logic [DIM_W-1:0]   col_q, col_d, row_q, row_d;
    logic [PIX_W-1:0]   top_prev_q, top_prev_d, bot_prev_q, bot_prev_d;
    logic               win_valid_q, win_valid_d;
    logic [4*PIX_W-1:0] win_data_q, win_data_d;
    logic [DIM_W-1:0]   win_row_q, win_row_d, win_col_q, win_col_d;
    logic               done_q, done_d, cfg_err_q, cfg_err_d;

    logic [PIX_W-1:0]   line_buf [MAX_W];
    logic [AW-1:0]      col_addr;
    logic [PIX_W-1:0]   top, tl, tr, bl, br;
    logic [PIX_W-1:0]   r_px, gr_px, gb_px, b_px;
    logic               accept, size_ok, last_col, last_row;

    assign col_addr  = col_q[AW-1:0];
    assign top       = line_buf[col_addr];
    assign busy      = (state_q != IDLE);
    assign pix_ready = ((state_q == FILL) || (state_q == STREAM)) && (!win_valid_q || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign size_ok   = (img_width >= DIM_W'(2)) && (img_width <= DIM_W'(MAX_W)) &&
                       (img_height >= DIM_W'(2));
    assign last_col  = (col_q == width_q - DIM_W'(1));
    assign last_row  = (row_q == height_q - DIM_W'(1));

    assign tl = top_prev_q;
    assign tr = top;
    assign bl = bot_prev_q;
    assign br = pix_data;

    // Bayer phase of tl is (row-1, col-1), i.e. the inverted LSBs of the current position.
    always_comb begin
        {r_px, gr_px, gb_px, b_px} = {tl, tr, bl, br};
        case ({~row_q[0], ~col_q[0]})
            2'b00:   {r_px, gr_px, gb_px, b_px} = {tl, tr, bl, br};
            2'b01:   {r_px, gr_px, gb_px, b_px} = {tr, tl, br, bl};
            2'b10:   {r_px, gr_px, gb_px, b_px} = {bl, br, tl, tr};
            default: {r_px, gr_px, gb_px, b_px} = {br, bl, tr, tl};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        col_d       = col_q;
        row_d       = row_q;
        top_prev_d  = top_prev_q;
        bot_prev_d  = bot_prev_q;
        win_valid_d = win_valid_q && !win_ready;
        win_data_d  = win_data_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_ok) begin
                        width_d  = img_width;
                        height_d = img_height;
                        col_d    = '0;
                        row_d    = '0;
                        state_d  = FILL;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            FILL, STREAM: begin
                if (accept) begin
                    top_prev_d = top;
                    bot_prev_d = pix_data;
                    if ((state_q == STREAM) && (col_q != '0)) begin
                        win_valid_d = 1'b1;
                        win_data_d  = {r_px, gr_px, gb_px, b_px};
                        win_row_d   = row_q;
                        win_col_d   = col_q;
                    end
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = FLUSH;
                        end else begin
                            row_d = row_q + DIM_W'(1);
                            if (state_q == FILL) state_d = STREAM;
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (!win_valid_q || win_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            top_prev_q  <= '0;
            bot_prev_q  <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_q       <= col_d;
            row_q       <= row_d;
            top_prev_q  <= top_prev_d;
            bot_prev_q  <= bot_prev_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Line buffer holds the previous row; contents are never reset.
    always_ff @(posedge clk) begin
        if (accept) line_buf[col_addr] <= pix_data;
    end

    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

`ifdef BWS_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start && size_ok) begin
            stall_d = '0;
        end else if (busy && win_valid_q && !win_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_bayer_window_stream.sv
// Directed and randomised-gap bench for bayer_window_stream with a queue scoreboard of expected windows.
module tb_bayer_window_stream;
    localparam int PIX_W = 8;
    localparam int MAX_W = 4096;
    localparam int DIM_W = 13;

    typedef struct packed {
        logic [DIM_W-1:0]   row;
        logic [DIM_W-1:0]   col;
        logic [4*PIX_W-1:0] data;
    } win_t;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               start;
    logic [DIM_W-1:0]   img_width;
    logic [DIM_W-1:0]   img_height;
    logic               pix_valid;
    logic [PIX_W-1:0]   pix_data;
    logic               pix_ready;
    logic               win_valid;
    logic [4*PIX_W-1:0] win_data;
    logic [DIM_W-1:0]   win_row;
    logic [DIM_W-1:0]   win_col;
    logic               win_ready;
    logic               busy;
    logic               done;
    logic               cfg_err;
    logic [31:0]        stall_cycles;

    int errors   = 0;
    int checks   = 0;
    int winCount = 0;

    win_t expQ[$];
    win_t gotWin[$];
    win_t monExp;
    win_t monGot;
    logic [PIX_W-1:0] frameBuf [0:255];

    bayer_window_stream #(.PIX_W(PIX_W), .MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .img_width(img_width), .img_height(img_height),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .win_valid(win_valid), .win_data(win_data), .win_row(win_row), .win_col(win_col),
        .win_ready(win_ready), .busy(busy), .done(done), .cfg_err(cfg_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference window from the stored frame using the RGGB phase of the top-left pixel.
    function automatic win_t refWin(input int w, input int r, input int c);
        logic [PIX_W-1:0] tl, tr, bl, br;
        win_t e;
        tl = frameBuf[(r-1)*w + c-1];
        tr = frameBuf[(r-1)*w + c];
        bl = frameBuf[r*w + c-1];
        br = frameBuf[r*w + c];
        e.row = DIM_W'(r);
        e.col = DIM_W'(c);
        case ({((r-1) % 2) == 1, ((c-1) % 2) == 1})
            2'b00:   e.data = {tl, tr, bl, br};
            2'b01:   e.data = {tr, tl, br, bl};
            2'b10:   e.data = {bl, br, tl, tr};
            default: e.data = {br, bl, tr, tl};
        endcase
        return e;
    endfunction

    // Scoreboard: every transferred window is popped and compared.
    always @(negedge clk) begin
        if (n_rst && win_valid && win_ready) begin
            monGot.row  = win_row;
            monGot.col  = win_col;
            monGot.data = win_data;
            gotWin.push_back(monGot);
            winCount++;
            checkOutput("window_expected", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checkOutput("win_row", 64'(win_row), 64'(monExp.row));
                checkOutput("win_col", 64'(win_col), 64'(monExp.col));
                checkOutput("win_data", 64'(win_data), 64'(monExp.data));
            end
        end
    end

    task automatic applyStimulus(input int w, input int idx, input int gapMax);
        int r;
        int c;
        int budget;
        r = idx / w;
        c = idx % w;
        if (gapMax > 0) begin
            repeat ($urandom_range(0, gapMax)) begin
                pix_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        pix_valid = 1'b1;
        pix_data  = frameBuf[idx];
        budget    = 0;
        @(negedge clk);
        while (!pix_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("pix_accept_timeout", 64'(budget < 100), 64'd1);
        @(posedge clk);
        if (r >= 1 && c >= 1) expQ.push_back(refWin(w, r, c));
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic startFrame(input int w, input int h);
        winCount = 0;
        gotWin.delete();
        start      = 1'b1;
        img_width  = DIM_W'(w);
        img_height = DIM_W'(h);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after the edge that accepted the last pixel.
    task automatic finishFrame(input int expWins);
        @(negedge clk);
        checkOutput("last_win_valid", 64'(win_valid), 64'd1);
        checkOutput("done_early", 64'(done), 64'd0);
        @(negedge clk);
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        checkOutput("win_valid_after_done", 64'(win_valid), 64'd0);
        checkOutput("window_count", 64'(winCount), 64'(expWins));
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_rst      = 1'b0;
        start      = 1'b0;
        img_width  = '0;
        img_height = '0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        win_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_win_valid", 64'(win_valid), 64'd0);
        checkOutput("rst_win_data", 64'(win_data), 64'd0);
        checkOutput("rst_pix_ready", 64'(pix_ready), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_cfg_err", 64'(cfg_err), 64'd0);
        checkOutput("rst_stall", 64'(stall_cycles), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] 4x3 frame, start while busy ignored");
        for (int i = 0; i < 12; i++) frameBuf[i] = PIX_W'(i);
        startFrame(4, 3);
        @(negedge clk);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(4, i, 0);
        start      = 1'b1;
        img_width  = DIM_W'(2);
        img_height = DIM_W'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("start_busy_cfg_err", 64'(cfg_err), 64'd0);
        checkOutput("start_busy_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 3; i < 12; i++) applyStimulus(4, i, 0);
        finishFrame(6);
        checkOutput("w0_pos", 64'({gotWin[0].row, gotWin[0].col}), 64'({13'd1, 13'd1}));
        checkOutput("w0_data", 64'(gotWin[0].data), 64'h0001_0405);
        checkOutput("w1_pos", 64'({gotWin[1].row, gotWin[1].col}), 64'({13'd1, 13'd2}));
        checkOutput("w1_data", 64'(gotWin[1].data), 64'h0201_0605);
        checkOutput("w3_pos", 64'({gotWin[3].row, gotWin[3].col}), 64'({13'd2, 13'd1}));
        checkOutput("w3_data", 64'(gotWin[3].data), 64'h0809_0405);
        checkOutput("w4_data", 64'(gotWin[4].data), 64'h0A09_0605);

        $display("[TB] 4x3 frame with 5-cycle backpressure");
        startFrame(4, 3);
        for (int i = 0; i < 7; i++) applyStimulus(4, i, 0);
        win_ready = 1'b0;
        pix_valid = 1'b1;
        pix_data  = frameBuf[7];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall_pix_ready", 64'(pix_ready), 64'd0);
            checkOutput("stall_win_valid", 64'(win_valid), 64'd1);
            checkOutput("stall_win_data", 64'(win_data), 64'h0201_0605);
            @(posedge clk);
            #1;
        end
        win_ready = 1'b1;
        for (int i = 7; i < 12; i++) applyStimulus(4, i, 0);
        finishFrame(6);
`ifdef BWS_STALL_CNT_EN
        checkOutput("stall_cycles", 64'(stall_cycles), 64'd5);
`else
        checkOutput("stall_cycles", 64'(stall_cycles), 64'd0);
`endif

        $display("[TB] illegal sizes");
        startFrame(1, 5);
        @(negedge clk);
        checkOutput("cfg_err_w1", 64'(cfg_err), 64'd1);
        checkOutput("cfg_err_w1_busy", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("cfg_err_pulse", 64'(cfg_err), 64'd0);
        @(posedge clk);
        #1;
        startFrame(MAX_W + 1, 4);
        @(negedge clk);
        checkOutput("cfg_err_wmax", 64'(cfg_err), 64'd1);
        checkOutput("cfg_err_wmax_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-frame, then 2x2 frame");
        startFrame(4, 3);
        for (int i = 0; i < 6; i++) applyStimulus(4, i, 0);
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        expQ.delete();
        @(negedge clk);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_win_valid", 64'(win_valid), 64'd0);
        checkOutput("mid_rst_win_data", 64'(win_data), 64'd0);
        checkOutput("mid_rst_win_pos", 64'({win_row, win_col}), 64'd0);
        checkOutput("mid_rst_pix_ready", 64'(pix_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("mid_rst_no_done", 64'(done), 64'd0);
        end
        @(posedge clk);
        #1;
        frameBuf[0] = 8'd10;
        frameBuf[1] = 8'd20;
        frameBuf[2] = 8'd30;
        frameBuf[3] = 8'd40;
        startFrame(2, 2);
        for (int i = 0; i < 4; i++) applyStimulus(2, i, 0);
        finishFrame(1);
        checkOutput("w2x2_data", 64'(gotWin[0].data), 64'h0A14_1E28);

        $display("[TB] 16x8 frame with random pixel gaps");
        for (int i = 0; i < 128; i++) frameBuf[i] = PIX_W'($urandom_range(0, 255));
        startFrame(16, 8);
        for (int i = 0; i < 128; i++) applyStimulus(16, i, 3);
        finishFrame(105);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
